// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub_ctrl
// Description : Multi-cycle wide adder/subtractor sequencer. One 4-bit
//               add/sub slice is reused across NIBBLES nibbles, LSB first.
//               The carry is chained between nibbles through a register.
//               Flags: carry = carry on add, borrow on subtract;
//                      overflow = signed overflow.
// Parameters  : NIBBLES - operand width in nibbles (W = 4*NIBBLES), 2..16
// Ports       : clk      in   clock, rising edge
//               rst_n    in   synchronous reset, active-low
//               start    in   request, sampled only in IDLE
//               op       in   0 = A+B, 1 = A-B (sampled with start)
//               a, b     in   W-bit operands (sampled with start)
//               busy     out  high while RUN or DONE
//               done     out  one-cycle pulse; result/flags valid from here
//               result   out  W-bit sum or difference
//               carry    out  carry (add) / borrow (sub) out of the MSB slice
//               overflow out  signed overflow of the MSB slice
// Options     : define ADDSUB_SAT_EN to clamp the result on signed overflow
//               to 0111..1 / 1000..0; flags are reported unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        cin_q, cin_d;
  logic                        op_q, op_d;
  logic [NIBBLES-1:0][3:0]     a_q, a_d;
  logic [NIBBLES-1:0][3:0]     b_q, b_d;
  logic [NIBBLES-1:0][3:0]     result_q, result_d;
  logic                        carry_q, carry_d;
  logic                        overflow_q, overflow_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Shared 4-bit slice. Subtraction is A + ~B + 1, with the +1 supplied by
  // loading the carry register with op at start.
  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [4:0] w_sum;
  logic       w_c_into_bit3;
  logic       w_last;

  assign w_a_nib = a_q[idx_q];
  assign w_b_nib = b_q[idx_q] ^ {4{op_q}};
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, cin_q};
  // Sum bit 3 is a3 ^ b3 ^ c3, so the carry into bit 3 falls out directly.
  assign w_c_into_bit3 = w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3];
  assign w_last = (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cin_d      = cin_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cin_d   = op;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        result_d[idx_q] = w_sum[3:0];
        cin_d           = w_sum[4];
        if (w_last) begin
          carry_d    = w_sum[4] ^ op_q;
          overflow_d = w_c_into_bit3 ^ w_sum[4];
`ifdef ADDSUB_SAT_EN
          // On overflow the true result's sign is the sign of A.
          if (w_c_into_bit3 ^ w_sum[4]) begin
            result_d = {a_q[NIBBLES-1][3], {(4*NIBBLES-1){~a_q[NIBBLES-1][3]}}};
          end
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered versions of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cin_q      <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cin_q      <= cin_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_addsub_ctrl
// Description : Scoreboard bench for nibble_serial_addsub_ctrl (NIBBLES=4).
//               Expected results come from a plain-arithmetic model of
//               W-bit add/sub; a monitor compares them whenever done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: integer arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input int due);
    exp_t   m;
    longint ux, uy, sx, sy, ut, st, smax, smin;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (!sub) begin
      ut  = ux + uy;
      st  = sx + sy;
      m.c = (ut >= (longint'(1) <<< W));
    end else begin
      ut  = ux - uy;
      st  = sx - sy;
      m.c = (ux < uy);
    end
    m.res = ut[W-1:0];
    m.v   = (st > smax) || (st < smin);
`ifdef ADDSUB_SAT_EN
    if (m.v) m.res = (st > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    m.due = due;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_one_cycle", 64'(prev_done), 64'd0);
      check("busy_at_done", 64'(busy), 64'd1);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("carry", 64'(carry), 64'(e.c));
        check("overflow", 64'(overflow), 64'(e.v));
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
    prev_done = done;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_carry"}, 64'(carry), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  // Called at posedge+1 while idle. Scrambles inputs and pulses start during
  // RUN to confirm they are ignored, then waits for the DUT to return idle.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    int k;
    start = 1'b1;
    a     = x;
    b     = y;
    op    = sub;
    sb_q.push_back(model(x, y, sub, cyc + 1 + NIBBLES));
    @(posedge clk); #1;
    repeat (2) begin
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 1'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 expected idle within 100 cycles");
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(16'h1234, 16'h0FFF, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b1);

    // Randomized cases with corner operands mixed in.
    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom));
    end

    // Reset during RUN: no done pulse, outputs cleared on the next cycle.
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    op    = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Recovery after abort.
    run_op(16'hABCD, 16'h1234, 1'b1);
    run_op(16'h0F0F, 16'hF0F1, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
